sha256_compress_pipe: RTL and testbench
=======================================

// Module: sha256_compress_pipe
// PURPOSE
//  Parametrised SHA-256 compression engine; successor to the fixed one-round-per-cycle core.
//  Accepts one 512-bit block plus a 256-bit chaining value over valid/ready, expands W
//  on-chip (16-word sliding window), runs 64 rounds at UNROLL rounds/cycle, then adds the
//  chaining value. Returns the 256-bit digest over valid/ready. Sits between block padder and digest sink.
// PARAMETERS
//  UNROLL   1   rounds per clock; legal 1,2,4,8; any other value -> $error at elaboration
// PORTS
//  clk         in   1    clock
//  reset       in   1    async active-high reset
//  in_valid    in   1    block + chaining value valid
//  in_ready    out  1    engine can accept a block
//  use_iv      in   1    1: chain from FIPS 180-4 IV, ignore hash_in; 0: chain from hash_in
//  hash_in     in   256  chaining value; [255:224]=H0 ... [31:0]=H7
//  block_in    in   512  message block; [511:480]=W0 ... [31:0]=W15
//  out_valid   out  1    digest valid
//  out_ready   in   1    sink accepts digest
//  digest_out  out  256  H0..H7, same ordering as hash_in
//  busy        out  1    high in ROUND, FINAL or OUT
// BEHAVIOUR
//  Reset is one clock, asynchronous and active-high.
//  Reset (async): state=IDLE; in_ready=1; out_valid=0; busy=0; digest_out=0; round ctr=0;
//    the working and schedule registers are cleared. Reset mid-operation discards the in-flight block.
//  FSM: IDLE -> ROUND on in_valid&&in_ready; ROUND -> FINAL when 64 rounds done;
//    FINAL -> OUT (1 cycle); OUT -> IDLE on out_valid&&out_ready.
//  in_ready=1 only in IDLE, so no acceptance while OUT holds. hash_in, use_iv and block_in are
//    sampled only on the accept edge. The source may change them afterwards.
//  Accept edge: a..h and the saved chain value are loaded from the IV or from hash_in.
//    W window[0..15] is loaded from block_in.
//  ROUND: each cycle applies UNROLL chained rounds t..t+UNROLL-1 (combinational cascade).
//    Round counter is 6 bits and steps by UNROLL. Wt for t>=16 uses
//    W[t]=s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16], all mod 2^32. Window shifts by UNROLL/cycle.
//  K table: 64x32 constant ROM indexed by t.
//  FINAL: digest_out[i] <= chain[i] + working[i] mod 2^32, for each 32-bit lane.
//  Latency: out_valid rises exactly 64/UNROLL+1 cycles after the accept edge
//    (UNROLL=1:65, 2:33, 4:17, 8:9).
//  OUT: out_valid=1. digest_out is held stable until the handshake. out_valid drops on the
//    handshake edge. in_ready rises on that same edge. The next accept is possible 1 cycle later.
//  digest_out keeps its last value in IDLE. It does not change until the next FINAL.
//  in_valid is ignored while busy. No buffering, one block in flight.
//  The counter wrap (63->0 at UNROLL=1, 56->0 at UNROLL=8) happens only on ROUND->FINAL.
//    The counter must never exceed round 63.
// TESTING
//  UNROLL=1, use_iv=1, block "abc" = 0x61626380, 0..0, W15=0x18 ->
//    digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; out_valid 65 cycles after accept.
//  UNROLL=4, empty msg: W0=0x80000000, rest 0 ->
//    e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855; latency 17.
//  Two-block "abcdbcde...nopq" (448-bit): block1 with use_iv=1, block2 with use_iv=0 and hash_in = digest1 ->
//    248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1. Run for every UNROLL.
//  Backpressure: out_ready=0 for 10 cycles after out_valid -> digest_out stable, in_ready=0,
//    in_valid pulses ignored. Handshake -> in_ready=1 the same edge.
//  Reset at round 30 -> next cycle in_ready=1, out_valid=0, busy=0. A fresh "abc" block then
//    gives the correct digest.
//  Input change after accept: corrupt block_in and hash_in on the cycle after accept ->
//    the digest still matches the values sampled at accept.

Source files
------------

// File: rtl/sha256_compress_pipe.sv
// SHA-256 compression engine: one 512-bit block per transaction, UNROLL rounds per clock,
// with on-chip message schedule (16-word sliding window) and final chaining add.
module sha256_compress_pipe #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         use_iv,
    input  logic [255:0] hash_in,
    input  logic [511:0] block_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] digest_out,
    output logic         busy
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
        $error("sha256_compress_pipe: UNROLL must be 1, 2, 4 or 8");
    end

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, OUT} state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // One SHA-256 round on a packed {a,b,c,d,e,f,g,h} state.
    function automatic logic [255:0] sha_round(input logic [255:0] st, input logic [31:0] k,
                                               input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = st;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    state_t              state, state_nxt;
    logic [5:0]          rnd_ctr;
    logic [255:0]        work, chain;
    logic [15:0][31:0]   w_win;
    logic [15:0][31:0]   w_load, w_shift;
    logic [31:0]         w_ext [16+UNROLL];
    logic [255:0]        round_out, init_val, final_sum;
    logic                last_round;

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == OUT);
    assign busy       = (state != IDLE);
    assign init_val   = use_iv ? IV : hash_in;
    assign last_round = (rnd_ctr == 6'(64 - UNROLL));

    // Schedule extension feeds the round cascade; words generated here are chained so
    // later ones may depend on earlier ones within the same cycle.
    always_comb begin
        logic [255:0] st;
        for (int i = 0; i < 16; i++) begin
            w_ext[i]  = w_win[i];
            w_load[i] = block_in[511 - 32*i -: 32];
        end
        for (int j = 0; j < UNROLL; j++)
            w_ext[16+j] = ssig1(w_ext[14+j]) + w_ext[9+j] + ssig0(w_ext[1+j]) + w_ext[j];
        for (int i = 0; i < 16; i++)
            w_shift[i] = w_ext[i+UNROLL];
        st = work;
        for (int j = 0; j < UNROLL; j++)
            st = sha_round(st, K[rnd_ctr + 6'(j)], w_ext[j]);
        round_out = st;
        for (int i = 0; i < 8; i++)
            final_sum[32*i +: 32] = chain[32*i +: 32] + work[32*i +: 32];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ROUND;
            ROUND:   if (last_round) state_nxt = FINAL;
            FINAL:   state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rnd_ctr    <= '0;
            work       <= '0;
            chain      <= '0;
            w_win      <= '0;
            digest_out <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid) begin
                    work    <= init_val;
                    chain   <= init_val;
                    w_win   <= w_load;
                    rnd_ctr <= '0;
                end
                ROUND: begin
                    work  <= round_out;
                    w_win <= w_shift;
                    // the last step lands exactly on 64, so the 6-bit counter returns to 0
                    rnd_ctr <= rnd_ctr + 6'(UNROLL);
                end
                FINAL:   digest_out <= final_sum;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_compress_pipe.sv
// Runs the engine at UNROLL=1,2,4,8 side by side on shared stimulus; a queue of expected
// digests is filled as blocks are sent and drained as each digest appears.
module tb_sha256_compress_pipe;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         use_iv = 1'b0;
    logic [255:0] hash_in = '0;
    logic [511:0] block_in = '0;
    logic         out_ready = 1'b0;
    logic [3:0]   in_ready, out_valid, busy;
    logic [255:0] digest [4];

    int checks = 0;
    int errors = 0;
    logic [255:0] exp_q [$];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        sha256_compress_pipe #(.UNROLL(1 << k)) u_dut (
            .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[k]),
            .use_iv(use_iv), .hash_in(hash_in), .block_in(block_in),
            .out_valid(out_valid[k]), .out_ready(out_ready), .digest_out(digest[k]),
            .busy(busy[k]));
    end

    localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, {15{32'h0}}};
    localparam logic [511:0] BLK_2A = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
        32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_2B = {{15{32'h0}}, 32'h000001c0};
    localparam logic [255:0] D_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] D_2A = 256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
    localparam logic [255:0] D_2B = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drives one block for a single accept edge, then scrambles the inputs.
    task automatic send(input bit iv, input logic [255:0] h, input logic [511:0] b,
                        input logic [255:0] exp, input bit track);
        @(negedge clk);
        in_valid = 1'b1; use_iv = iv; hash_in = h; block_in = b;
        if (track) exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        use_iv   = ~iv;
        hash_in  = {8{$urandom}};
        block_in = {16{$urandom}};
        chk("busy_after_accept", 256'(busy), 256'hf);
        chk("in_ready_after_accept", 256'(in_ready), 256'h0);
    endtask

    task automatic wait_out(input bit backpressure);
        logic [3:0]   seen = '0;
        logic [255:0] exp;
        for (int cyc = 1; cyc <= 100 && seen != 4'hf; cyc++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && !seen[k]) begin
                    seen[k] = 1'b1;
                    chk($sformatf("latency_u%0d", 1 << k), 256'(cyc), 256'(64 / (1 << k) + 1));
                end
            end
        end
        chk("out_valid_timeout", 256'(seen), 256'hf);
        exp = exp_q.pop_front();
        for (int k = 0; k < 4; k++)
            chk($sformatf("digest_u%0d", 1 << k), digest[k], exp);
        if (backpressure) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                in_valid = c[0]; block_in = {16{$urandom}};
                @(posedge clk); #1;
                chk("bp_in_ready", 256'(in_ready), 256'h0);
                chk("bp_out_valid", 256'(out_valid), 256'hf);
                chk("bp_digest_u1", digest[0], exp);
                chk("bp_digest_u8", digest[3], exp);
            end
            in_valid = 1'b0;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hs_out_valid", 256'(out_valid), 256'h0);
        chk("hs_in_ready", 256'(in_ready), 256'hf);
        chk("hs_busy", 256'(busy), 256'h0);
        @(posedge clk); #1;
        chk("idle_digest_held", digest[2], exp);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_in_ready", 256'(in_ready), 256'hf);
        chk("rst_out_valid", 256'(out_valid), 256'h0);
        chk("rst_busy", 256'(busy), 256'h0);
        chk("rst_digest", digest[0] | digest[3], 256'h0);

        send(1'b1, '0, BLK_ABC, D_ABC, 1'b1);
        wait_out(1'b1);
        send(1'b1, {8{32'h5a5a5a5a}}, BLK_EMPTY, D_EMPTY, 1'b1);
        wait_out(1'b0);
        send(1'b1, '0, BLK_2A, D_2A, 1'b1);
        wait_out(1'b0);
        send(1'b0, D_2A, BLK_2B, D_2B, 1'b1);
        wait_out(1'b0);

        // abort mid-flight: nothing from this block may surface
        send(1'b1, '0, BLK_EMPTY, '0, 1'b0);
        repeat (29) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        #1;
        chk("midrst_in_ready", 256'(in_ready), 256'hf);
        chk("midrst_out_valid", 256'(out_valid), 256'h0);
        chk("midrst_busy", 256'(busy), 256'h0);
        chk("midrst_digest", digest[1], 256'h0);
        send(1'b1, '0, BLK_ABC, D_ABC, 1'b1);
        wait_out(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
